// File: rtl/stencil_window_sum_pkg.sv
// stencil_pkg: width helpers shared by the KxK box-sum stencil.
// Optional feature macro (used by the top): STENCIL_SAT_EN.
package stencil_pkg;

    // Ceiling log2, with a floor of 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    // Accumulator width that cannot overflow for K*K unsigned taps.
    function automatic int acc_w(input int data_w, input int k);
        return data_w + clog2(k * k);
    endfunction

    // Counter width able to hold 0..n-1, never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // Counter types for the default 64x64 frame; the top sizes its own
    // counters from IMG_W/IMG_H with cnt_w().
    typedef logic [cnt_w(64)-1:0] col_t;
    typedef logic [cnt_w(64)-1:0] row_t;

endpackage

// File: rtl/stencil_window_sum_line_buffer.sv
// stencil_line_buffer: DEPTH-entry delay line that shifts only when enabled.
// The output is the sample pushed DEPTH enables ago, i.e. the pixel one row up.
module stencil_line_buffer
    import stencil_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Next state: shift the whole line by one on enable, otherwise hold.
    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d[0] = din;
            for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
        end
    end

    // Storage needs no reset: stale contents are masked by the row counter.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/stencil_window_sum.sv
// stencil_window_sum: streaming KxK box sum over a raster image with
// valid/ready handshakes, edge masking and frame-end marking.
// Optional macro STENCIL_SAT_EN: saturate the sum to DATA_W bits instead of wrapping.
module stencil_window_sum
    import stencil_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int K      = 3,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int ACC_W = acc_w(DATA_W, K);
    localparam int COL_W = cnt_w(IMG_W);
    localparam int ROW_W = cnt_w(IMG_H);

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;

    // Window columns older than the incoming one; column 0 is the newest.
    logic [K-1:0][K-2:0][DATA_W-1:0] win_q, win_d;

    // tap[0] is the incoming pixel, tap[r] the same column r rows up.
    logic [DATA_W-1:0] tap [K];
    logic [ACC_W-1:0]  acc;
    logic [DATA_W-1:0] sum_out;
    logic              accept, complete, frame_end;

    assign in_ready  = reset & (!out_valid_q | out_ready);
    assign accept    = in_valid & in_ready;
    assign complete  = (row_q >= ROW_W'(K-1)) && (col_q >= COL_W'(K-1));
    assign frame_end = (row_q == ROW_W'(IMG_H-1)) && (col_q == COL_W'(IMG_W-1));
    assign tap[0]    = in_data;

    // Chain of K-1 line buffers, each adding one row of delay.
    for (genvar g = 1; g < K; g++) begin : g_lb
        stencil_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb (
            .clk  (clk),
            .en   (accept),
            .din  (tap[g-1]),
            .dout (tap[g])
        );
    end

    // Adder tree over the incoming column plus the K-1 stored columns.
    always_comb begin
        acc = '0;
        for (int r = 0; r < K; r++) begin
            acc = acc + ACC_W'(tap[r]);
            for (int c = 0; c < K-1; c++) acc = acc + ACC_W'(win_q[r][c]);
        end
    end

`ifdef STENCIL_SAT_EN
    assign sum_out = (|acc[ACC_W-1:DATA_W]) ? '1 : acc[DATA_W-1:0];
`else
    logic acc_hi_unused;
    assign acc_hi_unused = |acc[ACC_W-1:DATA_W];
    assign sum_out       = acc[DATA_W-1:0];
`endif

    // Next state: raster counters, window shift and output register load/drain.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept) begin
            if (col_q == COL_W'(IMG_W-1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(IMG_H-1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            for (int r = 0; r < K; r++) begin
                win_d[r][0] = tap[r];
                for (int c = 1; c < K-1; c++) win_d[r][c] = win_q[r][c-1];
            end
            if (complete) begin
                out_data_d  = sum_out;
                out_valid_d = 1'b1;
                out_last_d  = frame_end;
            end
        end
    end

    // Control and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            col_q       <= '0;
            row_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Window datapath; contents before the first full window are masked.
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_stencil_window_sum.sv
// Bench for stencil_window_sum (K=3, 8x6 frame, 16-bit). Reference sums are
// computed directly from a whole-frame array; build with STENCIL_SAT_EN to match a saturating DUT.
module tb_stencil_window_sum;

    localparam int DW = 16;
    localparam int KK = 3;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int NOUT = (W-KK+1)*(H-KK+1);

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    stencil_window_sum #(.DATA_W(DW), .K(KK), .IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] pix_q [$];
    logic [DW-1:0] exp_q [$];
    bit            last_q [$];
    int            got, first_vacc;
    logic [DW-1:0] first_out, last_out;

    typedef struct {
        int            mode;     // 0 constant, 1 ramp, 2 random
        logic [DW-1:0] val;
        int            gap_pct;
        int            stall_at; // output index after which out_ready drops for 10 cycles
        bit            rnd_rdy;
        bit            chk_fl;
        logic [DW-1:0] exp_first;
        logic [DW-1:0] exp_last;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Appends one frame of stimulus and its expected window sums.
    task automatic add_frame(input int mode, input logic [DW-1:0] val);
        logic [DW-1:0] f [H][W];
        longint s;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                case (mode)
                    0:       f[r][c] = val;
                    1:       f[r][c] = DW'(r*W + c);
                    default: f[r][c] = DW'($urandom);
                endcase
                pix_q.push_back(f[r][c]);
            end
        for (int r = KK-1; r < H; r++)
            for (int c = KK-1; c < W; c++) begin
                s = 0;
                for (int i = 0; i < KK; i++)
                    for (int j = 0; j < KK; j++) s += longint'(f[r-i][c-j]);
`ifdef STENCIL_SAT_EN
                exp_q.push_back((s > 65535) ? 16'hFFFF : DW'(s));
`else
                exp_q.push_back(DW'(s));
`endif
                last_q.push_back(r == H-1 && c == W-1);
            end
    endtask

    // Streams pix_q into the DUT and checks every output transfer against exp_q.
    task automatic stream(input int gap_pct, input int stall_at, input bit rnd_rdy);
        int cyc = 0, acc_cnt = 0, stall_left = 0, nexp;
        bit was_stall = 0;
        logic [DW-1:0] held_d;
        logic held_l;
        got = 0;
        first_vacc = -1;
        nexp = exp_q.size();
        while ((pix_q.size() > 0 || exp_q.size() > 0) && cyc < 20000) begin
            @(negedge clk);
            if (pix_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
                in_valid = 1'b1;
                in_data  = pix_q[0];
            end else begin
                in_valid = 1'b0;
                in_data  = DW'($urandom);
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else out_ready = rnd_rdy ? ($urandom_range(3) != 0) : 1'b1;
            #1;
            if (was_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(held_d));
                chk("hold_last", 32'(out_last), 32'(held_l));
            end
            if (out_valid && first_vacc < 0) first_vacc = acc_cnt;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_output actual=%0h expected=none", out_data);
                end else begin
                    if (got == 0) first_out = out_data;
                    last_out = out_data;
                    chk($sformatf("out_data[%0d]", got), 32'(out_data), 32'(exp_q.pop_front()));
                    chk($sformatf("out_last[%0d]", got), 32'(out_last), 32'(last_q.pop_front()));
                end
                got++;
                if (got == stall_at) stall_left = 10;
            end
            was_stall = out_valid && !out_ready;
            if (was_stall) begin
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                held_d = out_data;
                held_l = out_last;
            end
            if (in_valid && in_ready) begin
                void'(pix_q.pop_front());
                acc_cnt++;
            end
            cyc++;
        end
        chk("stream_timeout", 32'(cyc >= 20000), 32'd0);
        chk("out_count", 32'(got), 32'(nexp));
        pix_q.delete();
        exp_q.delete();
        last_q.delete();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("drained", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int i, cyc;
        vecs[0] = '{0, 16'h0001, 0,  -1, 1'b0, 1'b1, 16'd9,  16'd9};
        vecs[1] = '{1, 16'h0000, 0,  -1, 1'b0, 1'b1, 16'd81, 16'd342};
        vecs[2] = '{1, 16'h0000, 0,  12, 1'b0, 1'b1, 16'd81, 16'd342};
`ifdef STENCIL_SAT_EN
        vecs[3] = '{0, 16'hFFFF, 0,  -1, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF};
`else
        vecs[3] = '{0, 16'hFFFF, 0,  -1, 1'b0, 1'b1, 16'hFFF7, 16'hFFF7};
`endif
        vecs[4] = '{2, 16'h0000, 30, -1, 1'b1, 1'b0, 16'h0, 16'h0};

        reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int v = 0; v < 5; v++) begin
            add_frame(vecs[v].mode, vecs[v].val);
            stream(vecs[v].gap_pct, vecs[v].stall_at, vecs[v].rnd_rdy);
            if (vecs[v].chk_fl) begin
                chk($sformatf("v%0d_first", v), 32'(first_out), 32'(vecs[v].exp_first));
                chk($sformatf("v%0d_last", v), 32'(last_out), 32'(vecs[v].exp_last));
            end
            if (v == 0) chk("first_valid_after_accepts", 32'(first_vacc), 32'd19);
        end

        // Reset after 20 accepted ramp pixels, then a clean ramp frame.
        i = 0; cyc = 0;
        while (i < 20 && cyc < 1000) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = DW'(i); out_ready = 1'b1;
            #1;
            if (in_ready) i++;
            cyc++;
        end
        chk("partial_timeout", 32'(cyc >= 1000), 32'd0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("partial_out_valid", 32'(out_valid), 32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1; out_ready = 1'b1;
        add_frame(1, '0);
        stream(0, -1, 1'b0);
        chk("midrst_first", 32'(first_out), 32'd81);
        chk("midrst_last", 32'(last_out), 32'd342);

        // Two back-to-back random frames with input gaps and output backpressure.
        add_frame(2, '0);
        add_frame(2, '0);
        stream(40, -1, 1'b1);
        chk("two_frame_count", 32'(got), 32'(2*NOUT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
